// File: rtl/alu_seq.sv
// Registered sequential ALU with an optional W-cycle restoring divider.
// Define ALU_SEQ_DIVIDER_EN to build DIV/MOD; otherwise op codes 10/11 act as NOP.
module alu_seq #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start_i,
  input  logic [3:0]   op_i,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] rs,
  output logic [W-1:0] result_o,
  output logic         ov_o,
  output logic         dz_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [3:0] {
    OP_MOV   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_LSL   = 4'd6,
    OP_LSR   = 4'd7,
    OP_CMP   = 4'd8,
    OP_ABS   = 4'd9,
    OP_DIV   = 4'd10,
    OP_MOD   = 4'd11,
    OP_CLROV = 4'd12
  } op_t;

  localparam logic [W-1:0] W_VAL   = W'(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] result_n;
  logic         ov_n;
  logic         dz_n;
  logic         done_n;
  logic [W:0]   sum;

`ifdef ALU_SEQ_DIVIDER_EN
  typedef enum logic {IDLE, DIV} state_t;

  localparam int unsigned    CW   = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state, state_n;
  logic [W:0]    rem, rem_n;
  logic [W-1:0]  quo, quo_n;
  logic [W-1:0]  dvsr, dvsr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          mod_q, mod_n;
  logic [W+1:0]  rem_sh;
  logic [W+1:0]  diff;

  assign busy_o = (state == DIV);
`else
  assign busy_o = 1'b0;
`endif

  always_comb begin
    result_n = result_o;
    ov_n     = ov_o;
    dz_n     = dz_o;
    done_n   = 1'b0;
    sum      = '0;
`ifdef ALU_SEQ_DIVIDER_EN
    state_n  = state;
    rem_n    = rem;
    quo_n    = quo;
    dvsr_n   = dvsr;
    cnt_n    = cnt;
    mod_n    = mod_q;
    // quo doubles as the dividend shift register; its MSB feeds the remainder
    rem_sh   = {rem, quo[W-1]};
    diff     = rem_sh - {2'b00, dvsr};
`endif
    if (start_i && !busy_o) begin
      done_n   = 1'b1;
      dz_n     = 1'b0;
      result_n = '0;
      case (op_t'(op_i))
        OP_MOV: result_n = rs;
        OP_ADD: begin
          sum = {1'b0, acc} + {1'b0, rs} + {{W{1'b0}}, ov_o};
          {ov_n, result_n} = sum;
        end
        OP_SUB: begin
          sum = {1'b0, acc} + {1'b0, ~rs} + {{W{1'b0}}, 1'b1};
          {ov_n, result_n} = sum;
        end
        OP_AND: result_n = acc & rs;
        OP_OR:  result_n = acc | rs;
        OP_XOR: result_n = acc ^ rs;
        OP_LSL: result_n = (rs >= W_VAL) ? '0 : (acc << rs);
        OP_LSR: result_n = (rs >= W_VAL) ? '0 : (acc >> rs);
        OP_CMP: begin
          if ($signed(acc) < $signed(rs)) result_n = '0;
          else if (acc == rs)             result_n = W'(1);
          else                            result_n = W'(2);
        end
        OP_ABS: begin
          if (rs == MIN_NEG) begin
            result_n = rs;
            ov_n     = 1'b1;
          end else begin
            result_n = rs[W-1] ? -rs : rs;
            ov_n     = 1'b0;
          end
        end
`ifdef ALU_SEQ_DIVIDER_EN
        OP_DIV, OP_MOD: begin
          if (rs == '0) begin
            dz_n     = 1'b1;
            result_n = op_i[0] ? acc : '1;
          end else begin
            done_n   = 1'b0;
            result_n = result_o;
            dz_n     = dz_o;
            state_n  = DIV;
            rem_n    = '0;
            quo_n    = acc;
            dvsr_n   = rs;
            cnt_n    = '0;
            mod_n    = op_i[0];
          end
        end
`endif
        OP_CLROV: ov_n = 1'b0;
        default: ;
      endcase
    end
`ifdef ALU_SEQ_DIVIDER_EN
    else if (state == DIV) begin
      rem_n = diff[W+1] ? rem_sh[W:0] : diff[W:0];
      quo_n = {quo[W-2:0], ~diff[W+1]};
      cnt_n = cnt + 1'b1;
      if (cnt == LAST) begin
        state_n  = IDLE;
        done_n   = 1'b1;
        dz_n     = 1'b0;
        result_n = mod_q ? rem_n[W-1:0] : quo_n;
      end
    end
`endif
  end

`ifdef ALU_SEQ_DIVIDER_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      mod_q <= 1'b0;
    end else begin
      rem   <= rem_n;
      quo   <= quo_n;
      dvsr  <= dvsr_n;
      cnt   <= cnt_n;
      mod_q <= mod_n;
    end
  end
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      result_o <= '0;
      ov_o     <= 1'b0;
      dz_o     <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      result_o <= result_n;
      ov_o     <= ov_n;
      dz_o     <= dz_n;
      done_o   <= done_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model checked every cycle plus directed literal checks.
// Follows ALU_SEQ_DIVIDER_EN the same way the design does.
module tb_alu_seq;

  localparam int W = 8;
  localparam logic [3:0] OP_MOV = 4'd0, OP_ADD = 4'd1, OP_CMP = 4'd8, OP_ABS = 4'd9,
                         OP_LSL = 4'd6, OP_DIV = 4'd10, OP_MOD = 4'd11, OP_CLROV = 4'd12;

  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0;
  logic [3:0]   op_i = '0;
  logic [W-1:0] acc = '0;
  logic [W-1:0] rs = '0;
  logic [W-1:0] result_o;
  logic         ov_o, dz_o, busy_o, done_o;

  int n_chk = 0;
  int n_pass = 0;

  alu_seq #(.W(W)) dut (
    .CLK(CLK), .reset(reset), .start_i(start_i), .op_i(op_i), .acc(acc), .rs(rs),
    .result_o(result_o), .ov_o(ov_o), .dz_o(dz_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: outcome of one operation computed from plain integer arithmetic.
  function automatic void model_op(input int o, input int a, input int b, input bit ovi,
                                   output int r, output bit ovo, output bit dz, output bit multi);
    int mask = (1 << W) - 1;
    int half = 1 << (W - 1);
    int sa = (a >= half) ? a - (1 << W) : a;
    int sb = (b >= half) ? b - (1 << W) : b;
    r = 0; ovo = ovi; dz = 0; multi = 0;
    case (o)
      0: r = b;
      1: begin r = a + b + int'(ovi); ovo = (r > mask); r = r & mask; end
      2: begin ovo = (a >= b); r = (a - b) & mask; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (b >= W) ? 0 : ((a << b) & mask);
      7: r = (b >= W) ? 0 : (a >> b);
      8: r = (sa < sb) ? 0 : ((sa == sb) ? 1 : 2);
      9: begin
        if (sb == -half) begin r = b; ovo = 1; end
        else begin r = (sb < 0) ? -sb : sb; ovo = 0; end
      end
`ifdef ALU_SEQ_DIVIDER_EN
      10, 11: begin
        if (b == 0) begin dz = 1; r = (o == 10) ? mask : a; end
        else begin multi = 1; r = (o == 10) ? a / b : a % b; end
      end
`endif
      12: ovo = 0;
      default: r = 0;
    endcase
  endfunction

  int exp_res = 0, pend_res = 0, remain = 0;
  bit exp_ov = 0, exp_dz = 0, exp_busy = 0, exp_done = 0;

  always @(posedge CLK or posedge reset) begin
    int r; bit o, d, m;
    if (reset) begin
      exp_res = 0; exp_ov = 0; exp_dz = 0; exp_busy = 0; exp_done = 0; remain = 0;
    end else begin
      exp_done = 0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          exp_res = pend_res; exp_dz = 0; exp_busy = 0; exp_done = 1;
        end
      end else if (start_i) begin
        model_op(int'(op_i), int'(acc), int'(rs), exp_ov, r, o, d, m);
        if (m) begin
          pend_res = r; remain = W; exp_busy = 1;
        end else begin
          exp_res = r; exp_ov = o; exp_dz = d; exp_done = 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("result", 32'(result_o), 32'(exp_res));
    chk("ov", 32'(ov_o), 32'(exp_ov));
    chk("dz", 32'(dz_o), 32'(exp_dz));
    chk("busy", 32'(busy_o), 32'(exp_busy));
    chk("done", 32'(done_o), 32'(exp_done));
  end

  // Issue one op and wait for its done pulse; with hold, start stays high during busy.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, output int lat, output int busy_n);
    @(negedge CLK);
    start_i = 1'b1; op_i = o; acc = a; rs = b;
    @(negedge CLK);
    lat = 0; busy_n = 0;
    start_i = 1'b0;
    while (!done_o && lat < 40) begin
      busy_n += int'(busy_o);
      start_i = hold && (lat < W - 1);
      op_i = OP_ADD; acc = W'($urandom); rs = W'($urandom);
      @(negedge CLK);
      lat++;
    end
    start_i = 1'b0;
    chk("done_seen", 32'(done_o), 32'd1);
  endtask

  initial begin
    int lat, bn;
    #1 reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    chk("rst_result", 32'(result_o), 32'h0);

    run_op(OP_CLROV, 8'h00, 8'h00, 0, lat, bn);
    run_op(OP_ADD, 8'hF0, 8'h20, 0, lat, bn);
    chk("add1_res", 32'(result_o), 32'h10);
    chk("add1_ov", 32'(ov_o), 32'd1);
    chk("add1_lat", 32'(lat), 32'd0);
    run_op(OP_ADD, 8'h01, 8'h01, 0, lat, bn);
    chk("add2_res", 32'(result_o), 32'h03);

    run_op(OP_DIV, 8'd200, 8'd7, 1, lat, bn);
`ifdef ALU_SEQ_DIVIDER_EN
    chk("div_res", 32'(result_o), 32'd28);
    chk("div_lat", 32'(lat), 32'd8);
    chk("div_busy", 32'(bn), 32'd8);
`else
    chk("div_res", 32'(result_o), 32'd0);
    chk("div_busy", 32'(bn), 32'd0);
    chk("div_ov", 32'(ov_o), 32'd0);
`endif
    @(negedge CLK);
    chk("single_done", 32'(done_o), 32'd0);

    run_op(OP_MOD, 8'd200, 8'd7, 0, lat, bn);
`ifdef ALU_SEQ_DIVIDER_EN
    chk("mod_res", 32'(result_o), 32'd4);
`else
    chk("mod_res", 32'(result_o), 32'd0);
`endif

    run_op(OP_DIV, 8'h55, 8'h00, 0, lat, bn);
    chk("dz_lat", 32'(lat), 32'd0);
`ifdef ALU_SEQ_DIVIDER_EN
    chk("div0_res", 32'(result_o), 32'hFF);
    chk("div0_dz", 32'(dz_o), 32'd1);
`else
    chk("div0_res", 32'(result_o), 32'h00);
    chk("div0_dz", 32'(dz_o), 32'd0);
`endif
    run_op(OP_MOD, 8'h55, 8'h00, 0, lat, bn);
`ifdef ALU_SEQ_DIVIDER_EN
    chk("mod0_res", 32'(result_o), 32'h55);
    chk("mod0_dz", 32'(dz_o), 32'd1);
`endif
    run_op(OP_ADD, 8'h00, 8'h00, 0, lat, bn);
    chk("dz_clear", 32'(dz_o), 32'd0);

    run_op(OP_CMP, 8'h80, 8'h01, 0, lat, bn);
    chk("cmp_lt", 32'(result_o), 32'd0);
    run_op(OP_CMP, 8'h05, 8'h05, 0, lat, bn);
    chk("cmp_eq", 32'(result_o), 32'd1);
    run_op(OP_ABS, 8'h00, 8'h80, 0, lat, bn);
    chk("abs_res", 32'(result_o), 32'h80);
    chk("abs_ov", 32'(ov_o), 32'd1);
    run_op(OP_LSL, 8'h01, 8'd9, 0, lat, bn);
    chk("lsl_big", 32'(result_o), 32'h00);
    run_op(OP_DIV, 8'd200, 8'd7, 0, lat, bn);
    chk("div_keeps_ov", 32'(ov_o), 32'd1);

    // back-to-back single-cycle ops, one accepted per cycle
    for (int i = 0; i < 24; i++) begin
      logic [3:0] o;
      @(negedge CLK);
      o = 4'($urandom_range(0, 15));
`ifdef ALU_SEQ_DIVIDER_EN
      if (o == OP_DIV || o == OP_MOD) o = OP_CLROV;
`endif
      start_i = 1'b1; op_i = o; acc = W'($urandom); rs = W'($urandom_range(0, 12));
    end
    @(negedge CLK);
    start_i = 1'b0;

    run_op(OP_ABS, 8'h00, 8'h80, 0, lat, bn);
    run_op(OP_MOV, 8'h00, 8'h77, 0, lat, bn);
    @(negedge CLK);
    start_i = 1'b1; op_i = OP_DIV; acc = 8'd200; rs = 8'd7;
    @(negedge CLK);
    start_i = 1'b0;
    repeat (3) @(negedge CLK);
    #2 reset = 1'b1;
    #1;
    chk("arst_res", 32'(result_o), 32'h0);
    chk("arst_ov", 32'(ov_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    run_op(OP_MOV, 8'h00, 8'h3C, 0, lat, bn);
    chk("mov_res", 32'(result_o), 32'h3C);
    chk("mov_lat", 32'(lat), 32'd0);

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
